prog_updown_counter: RTL and testbench



---
 rtl/prog_cnt_pkg.sv | 33 +++
 rtl/prog_updown_counter_if.sv | 29 ++
 rtl/prog_cnt_next.sv | 61 ++++++
 rtl/prog_updown_counter.sv | 73 +++++++
 tb/tb_prog_updown_counter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_cnt_pkg.sv
// Shared definitions for the programmable up/down counter: counting modes and
// the priority-decoded command that drives the next-state logic.
package prog_cnt_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_CLR  = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_UP   = 3'd3,
        CMD_DN   = 3'd4
    } cnt_cmd_t;

    // clr beats load beats a single-direction step; both directions at once is a hold
    function automatic cnt_cmd_t decode_cmd(input logic clr, input logic load,
                                            input logic increase, input logic decrease);
        cnt_cmd_t cmd;
        if (clr)
            cmd = CMD_CLR;
        else if (load)
            cmd = CMD_LOAD;
        else if (increase && !decrease)
            cmd = CMD_UP;
        else if (decrease && !increase)
            cmd = CMD_DN;
        else
            cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/prog_updown_counter_if.sv
// Control/status bundle of the programmable up/down counter. The master side
// issues commands and the terminal value, the slave side reports count and flags.
interface prog_updown_counter_if #(
    parameter int WIDTH = 8
);

    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             increase;
    logic             decrease;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             upd_en;

    modport master (
        output clr, load, load_val, increase, decrease, limit,
        input  count, tc, ovf, unf, upd_en
    );

    modport slave (
        input  clr, load, load_val, increase, decrease, limit,
        output count, tc, ovf, unf, upd_en
    );

endinterface

// File: rtl/prog_cnt_next.sv
// Combinational next-state logic for the counter: given the current count, the
// terminal value and the decoded command, produce the next count, the boundary
// event, the sticky-flag set requests and the register-update condition.
module prog_cnt_next
    import prog_cnt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SAT_MODE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] load_val,
    input  cnt_cmd_t         cmd,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary,
    output logic             set_ovf,
    output logic             set_unf,
    output logic             upd_en
);

    localparam bit SAT = (SAT_MODE == CNT_SAT);

    // Next count and boundary detection; counts above a lowered limit still decrement normally
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        upd_en     = (cmd != CMD_HOLD);
        case (cmd)
            CMD_CLR: begin
                next_count = '0;
            end
            CMD_LOAD: begin
                next_count = (load_val > limit) ? limit : load_val;
            end
            CMD_UP: begin
                if (count < limit) begin
                    next_count = count + WIDTH'(1);
                end else begin
                    boundary   = 1'b1;
                    set_ovf    = 1'b1;
                    next_count = SAT ? limit : '0;
                end
            end
            CMD_DN: begin
                if (count != '0) begin
                    next_count = count - WIDTH'(1);
                end else begin
                    boundary   = 1'b1;
                    set_unf    = 1'b1;
                    next_count = SAT ? '0 : limit;
                end
            end
            default: begin
                next_count = count;
            end
        endcase
    end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with wrap or saturate behaviour, synchronous
// load/clear, a registered terminal-count pulse and sticky overflow/underflow.
// The count and flag bank only loads when upd_en is high so an ICG can be
// inferred; tc is kept outside that bank because it must fall back to 0 on idle cycles.
module prog_updown_counter
    import prog_cnt_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter int SAT_MODE  = CNT_WRAP
) (
    input logic                  clk,
    input logic                  rst,
    prog_updown_counter_if.slave bus
);

    cnt_cmd_t         cmd;
    logic [WIDTH-1:0] next_count;
    logic             boundary;
    logic             set_ovf;
    logic             set_unf;
    logic             upd_en;

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic             unf_q;

    assign cmd = decode_cmd(bus.clr, bus.load, bus.increase, bus.decrease);

    prog_cnt_next #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE)
    ) u_next (
        .count      (count_q),
        .limit      (bus.limit),
        .load_val   (bus.load_val),
        .cmd        (cmd),
        .next_count (next_count),
        .boundary   (boundary),
        .set_ovf    (set_ovf),
        .set_unf    (set_unf),
        .upd_en     (upd_en)
    );

    // Update-gated bank: count and sticky flags change only when a command is pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= WIDTH'(RESET_VAL);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (upd_en) begin
            count_q <= next_count;
            ovf_q   <= (cmd == CMD_CLR) ? 1'b0 : (ovf_q | set_ovf);
            unf_q   <= (cmd == CMD_CLR) ? 1'b0 : (unf_q | set_unf);
        end
    end

    // Terminal-count pulse: high for exactly the cycle after each boundary event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tc_q <= 1'b0;
        else
            tc_q <= boundary;
    end

    assign bus.count  = count_q;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.upd_en = upd_en;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Bench for the programmable up/down counter. A wrap-mode and a saturate-mode
// instance share one stimulus stream; a plain-arithmetic model of each is
// compared with the DUT outputs on every falling edge, and directed scenarios
// pin the model with hand-computed values before a long randomized run.
module tb_prog_updown_counter;

    localparam int W   = 8;
    localparam int RV0 = 0;
    localparam int RV1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         clr      = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] loadVal  = '0;
    logic         increase = 1'b0;
    logic         decrease = 1'b0;
    logic [W-1:0] limit    = 8'd5;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    int mCount[2] = '{RV0, RV1};
    int mTc[2]    = '{0, 0};
    int mOvf[2]   = '{0, 0};
    int mUnf[2]   = '{0, 0};
    int resetVal[2] = '{RV0, RV1};

    prog_updown_counter_if #(.WIDTH(W)) busW ();
    prog_updown_counter_if #(.WIDTH(W)) busS ();

    assign busW.clr = clr;       assign busS.clr = clr;
    assign busW.load = load;     assign busS.load = load;
    assign busW.load_val = loadVal; assign busS.load_val = loadVal;
    assign busW.increase = increase; assign busS.increase = increase;
    assign busW.decrease = decrease; assign busS.decrease = decrease;
    assign busW.limit = limit;   assign busS.limit = limit;

    prog_updown_counter #(.WIDTH(W), .RESET_VAL(RV0), .SAT_MODE(0)) dutWrap (
        .clk (clk),
        .rst (rst),
        .bus (busW)
    );

    prog_updown_counter #(.WIDTH(W), .RESET_VAL(RV1), .SAT_MODE(1)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (busS)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic l, input logic [W-1:0] lv,
                                 input logic inc, input logic dec, input logic [W-1:0] lim);
        clr      = c;
        load     = l;
        loadVal  = lv;
        increase = inc;
        decrease = dec;
        limit    = lim;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of the reference behaviour for instance i (0 = wrap, 1 = saturate)
    function automatic void modelClock(input int i);
        int c   = mCount[i];
        int lim = int'(limit);
        int evt = 0;
        if (clr) begin
            mCount[i] = 0;
            mOvf[i]   = 0;
            mUnf[i]   = 0;
        end else if (load) begin
            mCount[i] = (int'(loadVal) > lim) ? lim : int'(loadVal);
        end else if (increase && !decrease) begin
            if (c < lim) begin
                mCount[i] = (c + 1) % 256;
            end else begin
                evt = 1;
                mOvf[i] = 1;
                mCount[i] = (i == 1) ? lim : 0;
            end
        end else if (decrease && !increase) begin
            if (c > 0) begin
                mCount[i] = c - 1;
            end else begin
                evt = 1;
                mUnf[i] = 1;
                mCount[i] = (i == 1) ? 0 : lim;
            end
        end
        mTc[i] = evt;
    endfunction

    // Reference model state advances on each rising edge, resets asynchronously
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mCount[i] = resetVal[i];
                mTc[i] = 0;
                mOvf[i] = 0;
                mUnf[i] = 0;
            end
        end else begin
            modelClock(0);
            modelClock(1);
        end
    end

    // Continuous comparison of both instances against the model on falling edges
    always @(negedge clk) begin
        if (checkEn) begin
            int expUpd;
            expUpd = int'(clr | load | (increase ^ decrease));
            checkOutput("wrap count", int'(busW.count), mCount[0]);
            checkOutput("wrap tc", int'(busW.tc), mTc[0]);
            checkOutput("wrap ovf", int'(busW.ovf), mOvf[0]);
            checkOutput("wrap unf", int'(busW.unf), mUnf[0]);
            checkOutput("wrap upd_en", int'(busW.upd_en), expUpd);
            checkOutput("sat count", int'(busS.count), mCount[1]);
            checkOutput("sat tc", int'(busS.tc), mTc[1]);
            checkOutput("sat ovf", int'(busS.ovf), mOvf[1]);
            checkOutput("sat unf", int'(busS.unf), mUnf[1]);
            checkOutput("sat upd_en", int'(busS.upd_en), expUpd);
        end
    end

    initial begin
        int s1Exp[7] = '{1, 2, 3, 4, 5, 0, 1};
        int r;

        // Reset values
        #2 rst = 1'b0;
        checkEn = 1'b1;
        #1;
        checkOutput("reset wrap count", int'(busW.count), RV0);
        checkOutput("reset sat count", int'(busS.count), RV1);
        checkOutput("reset tc", int'(busW.tc), 0);
        checkOutput("reset ovf", int'(busS.ovf), 0);
        tick();
        rst = 1'b1;

        // Wrap counting through limit 5, saturate instance pins at 5
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5);
        for (int k = 0; k < 7; k++) begin
            tick();
            checkOutput("s1 wrap count", int'(busW.count), s1Exp[k]);
            checkOutput("s1 wrap tc", int'(busW.tc), (k == 5) ? 1 : 0);
            checkOutput("s1 upd_en", int'(busW.upd_en), 1);
        end
        checkOutput("s1 wrap ovf", int'(busW.ovf), 1);
        checkOutput("s2 sat count", int'(busS.count), 5);
        checkOutput("s2 sat tc", int'(busS.tc), 1);
        checkOutput("s2 sat ovf", int'(busS.ovf), 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5);
        tick();
        checkOutput("s2 clr count", int'(busS.count), 0);
        checkOutput("s2 clr ovf", int'(busS.ovf), 0);

        // Down-step at zero, then simultaneous up/down hold
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd9);
        tick();
        checkOutput("s3 wrap count", int'(busW.count), 9);
        checkOutput("s3 wrap unf", int'(busW.unf), 1);
        checkOutput("s3 wrap tc", int'(busW.tc), 1);
        checkOutput("s3 sat count", int'(busS.count), 0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd9);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("s3 hold count", int'(busW.count), 9);
            checkOutput("s3 hold upd_en", int'(busW.upd_en), 0);
            checkOutput("s3 hold tc", int'(busW.tc), 0);
        end

        // Load clipped to limit, then clr beats load
        applyStimulus(1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 8'd100);
        tick();
        checkOutput("s4 load count", int'(busW.count), 100);
        checkOutput("s4 load sat count", int'(busS.count), 100);
        applyStimulus(1'b1, 1'b1, 8'd200, 1'b0, 1'b0, 8'd100);
        tick();
        checkOutput("s4 clr wins", int'(busW.count), 0);

        // Limit lowered below count
        applyStimulus(1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 8'd100);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3);
        tick();
        checkOutput("s5 count kept", int'(busW.count), 7);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
        tick();
        checkOutput("s5 wrap count", int'(busW.count), 0);
        checkOutput("s5 sat count", int'(busS.count), 3);
        checkOutput("s5 sat ovf", int'(busS.ovf), 1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3);
        tick();
        checkOutput("s5 sat dec", int'(busS.count), 2);
        checkOutput("s5 wrap dec", int'(busW.count), 3);

        // Asynchronous reset mid-count
        applyStimulus(1'b0, 1'b1, 8'd41, 1'b0, 1'b0, 8'd100);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd100);
        tick();
        checkOutput("s6 count before", int'(busW.count), 42);
        #2 rst = 1'b0;
        #1;
        checkOutput("s6 wrap count", int'(busW.count), RV0);
        checkOutput("s6 sat count", int'(busS.count), RV1);
        checkOutput("s6 ovf", int'(busS.ovf), 0);
        checkOutput("s6 unf", int'(busW.unf), 0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd100);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("s6 idle count", int'(busS.count), RV1);
        checkOutput("s6 idle upd_en", int'(busS.upd_en), 0);

        // Randomized run
        for (int n = 0; n < 2000; n++) begin
            logic [W-1:0] lim;
            lim = limit;
            r = int'($urandom_range(0, 15));
            if (r == 0)
                lim = 8'd0;
            else if (r == 1)
                lim = 8'hFF;
            else if (r == 2)
                lim = 8'($urandom_range(0, 255));
            applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), lim);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, limit);
        tick();
        checkEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
